// File: rtl/dvp_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : dvp_frame_sched
// Description : Sequences DVP frame capture into DDR3 through the ddr3_write
//               master. Waits for a frame boundary, pulses control_go, gates
//               the pixel write enable to whole frames and ping-pongs the
//               write base address between two buffers. Reports frame count,
//               completion and overrun status to the HPS register block.
// Ports       : clk, reset_n          - clock, async active-low reset
//               start_req, stop_req   - one-cycle capture start / graceful stop
//               frame_num             - frames to capture (0 = continuous)
//               buffer_base           - buffer0 base address
//               frame_length          - bytes per frame
//               vsync_begin/_end      - synchronised vsync edge pulses
//               control_done          - ddr3_write done level
//               control_go/_write_*   - ddr3_write command interface
//               cap_en                - whole-frame write enable gate
//               busy, cap_done, overrun, frame_cnt, buf_sel - status
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_frame_sched #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_req,
    input  logic              stop_req,
    input  logic [CNT_W-1:0]  frame_num,
    input  logic [ADDR_W-1:0] buffer_base,
    input  logic [LEN_W-1:0]  frame_length,
    input  logic              vsync_begin,
    input  logic              vsync_end,
    input  logic              control_done,
    output logic              control_go,
    output logic [ADDR_W-1:0] control_write_base,
    output logic [LEN_W-1:0]  control_write_length,
    output logic              cap_en,
    output logic              busy,
    output logic              cap_done,
    output logic              overrun,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              buf_sel
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_VS   = 3'd1,
        S_CAPTURE   = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t            r_state;
    state_t            w_next_state;

    logic              r_done_d;
    logic              r_go;
    logic              r_done_seen;
    logic              r_stop_pend;
    logic              r_cap_done;
    logic              r_overrun;
    logic              r_buf_sel;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic [CNT_W-1:0]  r_frame_num_l;
    logic [ADDR_W-1:0] r_base_l;
    logic [LEN_W-1:0]  r_len_l;

    logic              w_done_rise;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;
    logic              w_start;
    logic              w_go;
    logic              w_complete;
    logic              w_overrun_set;
    logic              w_done_seen_set;
    logic              w_stop_set;
    logic              w_finish;

    assign w_done_rise = control_done & ~r_done_d;
    assign w_cnt_inc   = r_frame_cnt + c_cnt_one;
    assign w_last      = (r_frame_num_l != '0) && (w_cnt_inc == r_frame_num_l);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and one-cycle action strobes for the datapath
    always_comb begin
        w_next_state    = r_state;
        w_start         = 1'b0;
        w_go            = 1'b0;
        w_complete      = 1'b0;
        w_overrun_set   = 1'b0;
        w_done_seen_set = 1'b0;
        w_stop_set      = 1'b0;
        w_finish        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // start beats a simultaneous stop; stop alone is ignored here
                if (start_req) begin
                    w_start      = 1'b1;
                    w_next_state = S_WAIT_VS;
                end
            end
            S_WAIT_VS: begin
                if (stop_req) begin
                    w_next_state = S_IDLE;
                end else if (vsync_end) begin
                    w_go         = 1'b1;
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // A done arriving with (or before) vsync_begin is remembered
                // so WAIT_DONE can complete on its first cycle.
                w_done_seen_set = w_done_rise;
                w_stop_set      = stop_req;
                if (vsync_begin) begin
                    w_next_state = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                w_stop_set = stop_req;
                if (w_done_rise || r_done_seen) begin
                    // done wins over a coincident vsync_end; that frame is skipped
                    w_complete   = 1'b1;
                    w_next_state = (w_last || r_stop_pend || stop_req) ? S_FINISH : S_WAIT_VS;
                end else if (vsync_end) begin
                    w_overrun_set = 1'b1;
                end
            end
            S_FINISH: begin
                w_finish     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_done_d      <= 1'b0;
            r_go          <= 1'b0;
            r_done_seen   <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_cap_done    <= 1'b0;
            r_overrun     <= 1'b0;
            r_buf_sel     <= 1'b0;
            r_frame_cnt   <= '0;
            r_frame_num_l <= '0;
            r_base_l      <= '0;
            r_len_l       <= '0;
        end else begin
            r_done_d <= control_done;
            r_go     <= w_go;
            if (w_start) begin
                r_frame_num_l <= frame_num;
                r_base_l      <= buffer_base;
                r_len_l       <= frame_length;
                r_frame_cnt   <= '0;
                r_cap_done    <= 1'b0;
                r_overrun     <= 1'b0;
                r_buf_sel     <= 1'b0;
                r_done_seen   <= 1'b0;
                r_stop_pend   <= 1'b0;
            end else begin
                if (w_done_seen_set) begin
                    r_done_seen <= 1'b1;
                end
                if (w_stop_set) begin
                    r_stop_pend <= 1'b1;
                end
                if (w_overrun_set) begin
                    r_overrun <= 1'b1;
                end
                if (w_complete) begin
                    r_frame_cnt <= w_cnt_inc;
                    r_buf_sel   <= ~r_buf_sel;
                    r_done_seen <= 1'b0;
                end
                if (w_finish) begin
                    r_cap_done  <= 1'b1;
                    r_stop_pend <= 1'b0;
                end
            end
        end
    end

    // While idle the base tracks buffer_base directly; once started it is
    // derived only from latched values, so it cannot move between go and done.
    always_comb begin
        if (r_state == S_IDLE) begin
            control_write_base = buffer_base;
        end else if (r_buf_sel) begin
            control_write_base = r_base_l + ADDR_W'(r_len_l);
        end else begin
            control_write_base = r_base_l;
        end
    end

    assign control_go           = r_go;
    assign control_write_length = r_len_l;
    assign cap_en               = (r_state == S_CAPTURE);
    assign busy                 = (r_state != S_IDLE);
    assign cap_done             = r_cap_done;
    assign overrun              = r_overrun;
    assign frame_cnt            = r_frame_cnt;
    assign buf_sel              = r_buf_sel;

endmodule
`default_nettype wire

// File: tb/tb_dvp_frame_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvp_frame_sched
// Description : Directed self-checking bench for dvp_frame_sched.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dvp_frame_sched;

    localparam logic [31:0] B0  = 32'h1034_5688;
    localparam logic [31:0] B1  = 32'h1047_1688;
    localparam logic [31:0] LEN = 32'h0012_C000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_req = 1'b0;
    logic        stop_req = 1'b0;
    logic [7:0]  frame_num = 8'd1;
    logic [31:0] buffer_base = B0;
    logic [31:0] frame_length = LEN;
    logic        vsync_begin = 1'b0;
    logic        vsync_end = 1'b0;
    logic        control_done = 1'b0;
    logic        control_go;
    logic [31:0] control_write_base;
    logic [31:0] control_write_length;
    logic        cap_en;
    logic        busy;
    logic        cap_done;
    logic        overrun;
    logic [7:0]  frame_cnt;
    logic        buf_sel;

    int total = 0;
    int bad   = 0;
    int go_cnt = 0;
    int g0;

    always #5 clk = ~clk;

    dvp_frame_sched #(.ADDR_W(32), .LEN_W(32), .CNT_W(8)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .start_req           (start_req),
        .stop_req            (stop_req),
        .frame_num           (frame_num),
        .buffer_base         (buffer_base),
        .frame_length        (frame_length),
        .vsync_begin         (vsync_begin),
        .vsync_end           (vsync_end),
        .control_done        (control_done),
        .control_go          (control_go),
        .control_write_base  (control_write_base),
        .control_write_length(control_write_length),
        .cap_en              (cap_en),
        .busy                (busy),
        .cap_done            (cap_done),
        .overrun             (overrun),
        .frame_cnt           (frame_cnt),
        .buf_sel             (buf_sel)
    );

    // Counts go pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (control_go === 1'b1) go_cnt <= go_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start_req = 1'b1; tick(); start_req = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_req = 1'b1; tick(); stop_req = 1'b0;
    endtask

    task automatic pulse_vse();
        vsync_end = 1'b1; tick(); vsync_end = 1'b0;
    endtask

    task automatic pulse_vsb();
        vsync_begin = 1'b1; tick(); vsync_begin = 1'b0;
    endtask

    task automatic pulse_done();
        control_done = 1'b1; tick(); control_done = 1'b0; tick();
    endtask

    // One clean frame starting in WAIT_VS: go, capture, vsync_begin, done
    task automatic do_frame(input string tag, input logic [31:0] exp_base);
        pulse_vse();
        chk({tag, "_go"}, control_go, 1'b1);
        chk({tag, "_base"}, control_write_base, exp_base);
        chk({tag, "_cap_en"}, cap_en, 1'b1);
        tick(3);
        chk({tag, "_go_width"}, control_go, 1'b0);
        pulse_vsb();
        chk({tag, "_cap_off"}, cap_en, 1'b0);
        tick();
        pulse_done();
    endtask

    initial begin
        // ---------------- reset ----------------
        reset_n = 1'b0;
        tick(2);
        chk("rst_go", control_go, 1'b0);
        chk("rst_cap_en", cap_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cap_done", cap_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'd0);
        chk("rst_buf_sel", buf_sel, 1'b0);
        chk("rst_len", control_write_length, 32'd0);
        chk("rst_base", control_write_base, B0);
        reset_n = 1'b1;
        tick(2);

        // ---------------- single frame ----------------
        g0 = go_cnt;
        frame_num = 8'd1;
        pulse_start();
        chk("sf_busy", busy, 1'b1);
        chk("sf_len", control_write_length, LEN);
        chk("sf_wait_cap_en", cap_en, 1'b0);
        do_frame("sf", B0);
        chk("sf_cnt_finish", frame_cnt, 8'd1);
        tick();
        chk("sf_cnt", frame_cnt, 8'd1);
        chk("sf_buf_sel", buf_sel, 1'b1);
        chk("sf_cap_done", cap_done, 1'b1);
        chk("sf_busy_end", busy, 1'b0);
        chk("sf_gos", go_cnt - g0, 1);

        // ---------------- ping-pong ----------------
        frame_num = 8'd3;
        pulse_start();
        chk("pp_cleared", {cap_done, buf_sel, frame_cnt}, 10'd0);
        do_frame("pp1", B0);
        do_frame("pp2", B1);
        do_frame("pp3", B0);
        tick();
        chk("pp_cnt", frame_cnt, 8'd3);
        chk("pp_cap_done", cap_done, 1'b1);
        chk("pp_overrun", overrun, 1'b0);

        // ---------------- overrun ----------------
        g0 = go_cnt;
        frame_num = 8'd2;
        pulse_start();
        pulse_vse();
        tick(2);
        pulse_vsb();
        tick();
        pulse_vse();
        chk("ov_flag", overrun, 1'b1);
        chk("ov_no_go", control_go, 1'b0);
        chk("ov_no_cap", cap_en, 1'b0);
        tick();
        pulse_done();
        chk("ov_cnt1", frame_cnt, 8'd1);
        chk("ov_busy", busy, 1'b1);
        do_frame("ov2", B1);
        tick();
        chk("ov_cnt2", frame_cnt, 8'd2);
        chk("ov_cap_done", cap_done, 1'b1);
        chk("ov_sticky", overrun, 1'b1);
        chk("ov_gos", go_cnt - g0, 2);

        // ---------------- continuous with stop ----------------
        frame_num = 8'd0;
        pulse_start();
        chk("ct_ov_clear", overrun, 1'b0);
        do_frame("ct1", B0);
        do_frame("ct2", B1);
        do_frame("ct3", B0);
        do_frame("ct4", B1);
        chk("ct_cnt4", frame_cnt, 8'd4);
        chk("ct_busy4", busy, 1'b1);
        pulse_vse();
        chk("ct5_base", control_write_base, B0);
        tick();
        pulse_stop();
        chk("ct5_still_cap", cap_en, 1'b1);
        tick();
        pulse_vsb();
        tick();
        pulse_done();
        tick();
        chk("ct_cnt5", frame_cnt, 8'd5);
        chk("ct_cap_done", cap_done, 1'b1);
        chk("ct_busy_end", busy, 1'b0);

        // ---------------- stop in WAIT_VS; start+stop in IDLE ----------------
        start_req = 1'b1; stop_req = 1'b1; tick(); start_req = 1'b0; stop_req = 1'b0;
        chk("ss_start_wins", busy, 1'b1);
        chk("ss_cap_done_clr", cap_done, 1'b0);
        tick(2);
        pulse_stop();
        chk("ws_abort_idle", busy, 1'b0);
        chk("ws_no_cap_done", cap_done, 1'b0);

        // ---------------- early done ----------------
        frame_num = 8'd1;
        pulse_start();
        pulse_vse();
        control_done = 1'b1; tick(); control_done = 1'b0;
        tick(2);
        pulse_vsb();
        chk("ed_wait_done_cnt", frame_cnt, 8'd0);
        tick();
        chk("ed_exit_cnt", frame_cnt, 8'd1);
        tick();
        chk("ed_cap_done", cap_done, 1'b1);
        chk("ed_idle", busy, 1'b0);
        tick(3);
        chk("ed_cnt_once", frame_cnt, 8'd1);

        // ---------------- reset mid-capture ----------------
        frame_num = 8'd3;
        pulse_start();
        do_frame("mr1", B0);
        pulse_vse();
        chk("mr_go_before", control_go, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mr_go", control_go, 1'b0);
        chk("mr_cap_en", cap_en, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_cnt", frame_cnt, 8'd0);
        chk("mr_buf_sel", buf_sel, 1'b0);
        chk("mr_len", control_write_length, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // ---------------- start while busy ----------------
        frame_num = 8'd1;
        pulse_start();
        pulse_vse();
        tick();
        pulse_vsb();
        frame_num    = 8'd5;
        buffer_base  = 32'h2000_0000;
        frame_length = 32'h0000_0100;
        pulse_start();
        chk("sb_busy", busy, 1'b1);
        chk("sb_base", control_write_base, B0);
        chk("sb_len", control_write_length, LEN);
        pulse_done();
        tick();
        chk("sb_cnt", frame_cnt, 8'd1);
        chk("sb_cap_done", cap_done, 1'b1);
        chk("sb_idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_frame_sched.md
Name: dvp_frame_sched

Overview:
Sequences DVP frame capture into DDR3 through the ddr3_write master.
- Waits for a frame boundary, then pulses control_go.
- Gates the pixel write enable to whole frames only.
- Ping-pongs the write base address between two buffers.
- Counts frames and reports completion and overrun status to the HPS-side register block.
- Operates in the clk domain. vsync_begin/vsync_end pulses are already synchronised into clk.

Parameters:
ADDR_W, 32, width of buffer base and write base.
LEN_W, 32, width of frame length.
CNT_W, 8, width of frame request and frame counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_req  in  1  one-cycle capture request
stop_req  in  1  one-cycle graceful stop request
frame_num  in  CNT_W  frames to capture; 0 = continuous until stop
buffer_base  in  ADDR_W  buffer0 base address
frame_length  in  LEN_W  bytes per frame
vsync_begin  in  1  one-cycle pulse, vsync rising (frame end)
vsync_end  in  1  one-cycle pulse, vsync falling (frame start)
control_done  in  1  ddr3_write done level
control_go  out  1  one-cycle start pulse to ddr3_write
control_write_base  out  ADDR_W  current target buffer address
control_write_length  out  LEN_W  latched frame_length
cap_en  out  1  AND-gate for user_write_buffer
busy  out  1  high in any state except IDLE
cap_done  out  1  sticky; requested frames complete
overrun  out  1  sticky; frame skipped because previous DDR write was unfinished
frame_cnt  out  CNT_W  frames completed since start
buf_sel  out  1  0 = buffer0, 1 = buffer1

Behaviour:
- Reset values: all outputs 0; state IDLE; control_write_base = buffer_base.
- done_rise = control_done & ~done_d, where done_d is a registered copy of control_done.
- start_req in IDLE:
  - latches frame_num, buffer_base and frame_length;
  - clears frame_cnt, cap_done, overrun and buf_sel;
  - moves to WAIT_VS.
- start_req while busy is ignored.
- States:
  - IDLE: waits for start_req.
  - WAIT_VS: on vsync_end, the next cycle has control_go=1 and cap_en=1, and the FSM enters CAPTURE. control_go is exactly one cycle wide.
  - CAPTURE: cap_en=1. A done_rise here sets done_seen. On vsync_begin: cap_en=0 the next cycle; go to WAIT_DONE.
  - WAIT_DONE: cap_en=0. On done_rise or done_seen:
    - frame_cnt+1 (wraps at 2^CNT_W);
    - buf_sel toggles;
    - done_seen clears;
    - if (frame_num!=0 and frame_cnt+1==frame_num) or stop_pend: go to FINISH;
    - else go to WAIT_VS.
  - WAIT_DONE overrun case: if vsync_end arrives before done, set overrun, stay in WAIT_DONE and issue no go for that frame.
  - FINISH: one cycle; sets cap_done=1; returns to IDLE.
- stop_req:
  - In WAIT_VS it aborts immediately to IDLE; cap_done is not set.
  - In CAPTURE or WAIT_DONE it sets stop_pend, so the current frame completes first.
  - In IDLE it is ignored.
  - start_req and stop_req in the same cycle in IDLE: start wins.
- Address and length:
  - control_write_base = buf_sel ? base_l + len_l : base_l, combinational from registered values.
  - The addition is an unsigned ADDR_W sum with wrap-around.
  - control_write_base is stable from control_go until done_rise.
  - control_write_length = len_l.
- Simultaneous events:
  - vsync_begin and done_rise in the same CAPTURE cycle: treat as done_seen, then complete in WAIT_DONE on the next cycle.
  - vsync_end and done_rise in the same WAIT_DONE cycle: done wins; no overrun; the frame is not captured, and the next capture waits for the following vsync_end.
- Mid-operation reset: async return to reset values. The ddr3_write transfer is left to its own reset.

Test Plan:
- Single-frame capture:
  - Stimulus: base=0x10345688, len=0x0012C000, frame_num=1, start_req, then vsync_end, then vsync_begin, then done_rise.
  - Required: one control_go with base 0x10345688; cap_en high only between the vsync pulses; frame_cnt=1; buf_sel=1; cap_done=1; busy=0.
- Ping-pong:
  - Stimulus: frame_num=3, three clean frames.
  - Required: bases 0x10345688, 0x10471688, 0x10345688; frame_cnt=3; cap_done=1.
- Overrun:
  - Stimulus: frame_num=2; done withheld past the next vsync_end.
  - Required: overrun=1; no control_go on that vsync_end; the second go comes on the following vsync_end; frame_cnt ends at 2.
- Continuous with stop:
  - Stimulus: frame_num=0; 4 frames; stop_req during the 5th CAPTURE.
  - Required: the 5th frame completes; frame_cnt=5; cap_done=1.
  - Also: stop_req in WAIT_VS gives IDLE with cap_done=0.
- Early done:
  - Stimulus: done_rise during CAPTURE, 3 cycles before vsync_begin.
  - Required: after vsync_begin, exit WAIT_DONE within 1 cycle; frame_cnt increments once.
- Reset and start-while-busy:
  - Stimulus: reset_n low mid-CAPTURE; separately, start_req during WAIT_DONE.
  - Required: reset gives all outputs 0 immediately; start_req while busy changes nothing.
